miriscv_lsu: RTL and testbench

- Load/store unit on the execute side of the miriscv core.
- Consumes the decoder's memory-access encoding (size codes MEM_ACCESS_WORD/HALF/BYTE/UHALF/UBYTE = 0..4) plus address and store data.
- Drives a single-outstanding req/gnt/rvalid data-memory bus.
- Returns formatted, sign- or zero-extended load data to the writeback mux and stalls the pipeline while a transaction is in flight.

---
 rtl/miriscv_decode_pkg.sv | 16 +
 rtl/miriscv_lsu_pkg.sv | 44 ++++
 rtl/miriscv_lsu_load_fmt.sv | 33 +++
 rtl/miriscv_lsu.sv | 138 +++++++++++++
 tb/tb_miriscv_lsu.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/miriscv_decode_pkg.sv
`default_nettype none
//============================================================================
// Module : miriscv_decode_pkg
// Brief  : Decoder encodings shared with execute-side units (memory sizes).
// Rev    : 1.0
//============================================================================
package miriscv_decode_pkg;

  localparam logic [2:0] MEM_ACCESS_WORD  = 3'd0;
  localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
  localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd2;
  localparam logic [2:0] MEM_ACCESS_UHALF = 3'd3;
  localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/miriscv_lsu_pkg.sv
`default_nettype none
//============================================================================
// Module : miriscv_lsu_pkg
// Brief  : LSU state encoding and byte-enable / alignment helpers.
// Rev    : 1.0
//============================================================================
package miriscv_lsu_pkg;

  import miriscv_decode_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      MEM_ACCESS_WORD:                   be = 4'b1111;
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: be = 4'b0001 << addr_lo;
      default:                           be = 4'b0000;
    endcase
    return be;
  endfunction

  // Illegal size codes are reported through the same fault path as misalignment.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (size)
      MEM_ACCESS_WORD:                   fault = (addr_lo != 2'b00);
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: fault = addr_lo[0];
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: fault = 1'b0;
      default:                           fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_lsu_load_fmt.sv
`default_nettype none
//============================================================================
// Module : miriscv_lsu_load_fmt
// Brief  : Selects the addressed lane of a read word and sign/zero-extends it.
// Rev    : 1.0
//============================================================================
module miriscv_lsu_load_fmt
  import miriscv_decode_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[8*addr_lo +: 8];
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (size)
      MEM_ACCESS_BYTE:  data = {{24{w_byte[7]}}, w_byte};
      MEM_ACCESS_UBYTE: data = {24'd0, w_byte};
      MEM_ACCESS_HALF:  data = {{16{w_half[15]}}, w_half};
      MEM_ACCESS_UHALF: data = {16'd0, w_half};
      default:          data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/miriscv_lsu.sv
`default_nettype none
//============================================================================
// Module : miriscv_lsu
// Brief  : Single-outstanding load/store unit on a req/gnt/rvalid data bus.
// Rev    : 1.0
//============================================================================
module miriscv_lsu
  import miriscv_decode_pkg::*;
  import miriscv_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_size_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_stall_o,
  output logic                  lsu_valid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_misalign_o,

  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  lsu_state_t            r_state;
  lsu_state_t            w_next_state;

  logic                  r_we;
  logic [2:0]            r_size;
  logic [1:0]            r_addr_lo;
  logic                  r_fault;
  logic [3:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_fault;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_capture;

  assign w_fault = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);

  always_comb begin
    w_wdata = lsu_wdata_i;
    case (lsu_size_i)
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: w_wdata = {2{lsu_wdata_i[15:0]}};
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: w_wdata = {4{lsu_wdata_i[7:0]}};
      default:                           w_wdata = lsu_wdata_i;
    endcase
  end

  miriscv_lsu_load_fmt u_load_fmt (
    .rdata   (data_rdata_i),
    .size    (r_size),
    .addr_lo (r_addr_lo),
    .data    (w_load_data)
  );

  // Response data is only meaningful once the request has been granted.
  assign w_capture = ((r_state == REQ) && data_gnt_i && data_rvalid_i) ||
                     ((r_state == RSP) && data_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (lsu_req_i) w_next_state = w_fault ? DONE : REQ;
      REQ:  if (data_gnt_i) w_next_state = data_rvalid_i ? DONE : RSP;
      RSP:  if (data_rvalid_i) w_next_state = DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    lsu_stall_o    = ((r_state == IDLE) && lsu_req_i) || (r_state == REQ) || (r_state == RSP);
    data_req_o     = (r_state == REQ);
    lsu_valid_o    = (r_state == DONE) && !r_fault;
    lsu_misalign_o = (r_state == DONE) && r_fault;
    lsu_rdata_o    = lsu_valid_o ? r_rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we      <= 1'b0;
      r_size    <= 3'd0;
      r_addr_lo <= 2'd0;
      r_fault   <= 1'b0;
      r_be      <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if ((r_state == IDLE) && lsu_req_i) begin
        r_fault <= w_fault;
        r_rdata <= '0;
        if (!w_fault) begin
          r_we      <= lsu_we_i;
          r_size    <= lsu_size_i;
          r_addr_lo <= lsu_addr_i[1:0];
          r_be      <= lsu_be(lsu_size_i, lsu_addr_i[1:0]);
          r_addr    <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
          r_wdata   <= w_wdata;
        end
      end
      if (w_capture) begin
        r_rdata <= r_we ? '0 : w_load_data;
      end
    end
  end

  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_addr_o  = r_addr;
  assign data_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
`default_nettype none
//============================================================================
// Module : tb_miriscv_lsu
// Brief  : Directed scoreboard bench for the load/store unit.
// Rev    : 1.0
//============================================================================
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_wdata_i = 32'd0;
  logic        lsu_stall_o;
  logic        lsu_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'd0;

  int errors = 0;
  int checks = 0;

  // {valid, misalign, rdata}
  logic [33:0] exp_q[$];

  miriscv_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_valid_o    (lsu_valid_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_misalign_o (lsu_misalign_o),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic void check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Completion monitor: every valid/misalign pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && (lsu_valid_o || lsu_misalign_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", {lsu_valid_o, lsu_misalign_o, lsu_rdata_o}, 34'd0);
      end else begin
        check("completion", {lsu_valid_o, lsu_misalign_o, lsu_rdata_o}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_dly, input logic same, input logic [31:0] bus_rdata,
                        input logic fault, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    @(posedge clk_i); #1;
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_size_i  = size;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    exp_q.push_back(fault ? {2'b01, 32'd0} : {2'b10, exp_rd});
    @(negedge clk_i);
    check({nm, "_stall_T"}, {33'd0, lsu_stall_o}, 34'd1);
    @(posedge clk_i); #1;
    if (fault) begin
      @(negedge clk_i);
      check({nm, "_fault_pulse"}, {31'd0, lsu_misalign_o, lsu_valid_o, data_req_o}, 34'b100);
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      @(negedge clk_i);
      check({nm, "_fault_noreq"}, {32'd0, data_req_o, lsu_misalign_o}, 34'd0);
    end else begin
      for (int i = 0; i < gnt_dly; i++) begin
        @(negedge clk_i);
        check({nm, "_wait_bus"}, {1'b0, data_req_o, data_we_o, exp_be == data_be_o,
                                  exp_addr == data_addr_o, lsu_stall_o, 28'd0},
              {1'b0, 1'b1, we, 1'b1, 1'b1, 1'b1, 28'd0});
        if (we) check({nm, "_wait_wdata"}, {2'b0, data_wdata_o}, {2'b0, exp_wdata});
        @(posedge clk_i); #1;
      end
      data_gnt_i    = 1'b1;
      data_rvalid_i = same;
      data_rdata_i  = same ? bus_rdata : 32'h0BAD_0BAD;
      @(negedge clk_i);
      check({nm, "_req"}, {29'd0, data_req_o, data_we_o, lsu_stall_o}, {29'd0, 1'b1, we, 1'b1});
      check({nm, "_be"}, {30'd0, data_be_o}, {30'd0, exp_be});
      check({nm, "_addr"}, {2'b0, data_addr_o}, {2'b0, exp_addr});
      if (we) check({nm, "_wdata"}, {2'b0, data_wdata_o}, {2'b0, exp_wdata});
      @(posedge clk_i); #1;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      if (!same) begin
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = bus_rdata;
        @(negedge clk_i);
        check({nm, "_rsp"}, {32'd0, lsu_stall_o, data_req_o}, 34'b10);
        @(posedge clk_i); #1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
      end
      @(negedge clk_i);
      check({nm, "_done"}, {32'd0, lsu_valid_o, lsu_stall_o}, 34'b10);
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ctrl", {29'd0, lsu_stall_o, lsu_valid_o, lsu_misalign_o, data_req_o, data_we_o}, 34'd0);
    check("reset_bus", {data_be_o, data_addr_o[29:0]}, 34'd0);
    check("reset_data", {2'b0, data_wdata_o | lsu_rdata_o}, 34'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    //      name     we    size  addr          wdata         dly same bus_rdata     flt exp_rd        be       addr          wdata
    run_op("lw",     1'b0, 3'd0, 32'h0000_0100, 32'h0,       0, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0);
    run_op("lb",     1'b0, 3'd2, 32'h0000_0203, 32'h0,       0, 1'b0, 32'h80FF_1234, 0, 32'hFFFF_FF80, 4'b1000, 32'h0000_0200, 32'h0);
    run_op("lbu",    1'b0, 3'd4, 32'h0000_0203, 32'h0,       1, 1'b0, 32'h80FF_1234, 0, 32'h0000_0080, 4'b1000, 32'h0000_0200, 32'h0);
    run_op("lhu",    1'b0, 3'd3, 32'h0000_0202, 32'h0,       0, 1'b0, 32'h80FF_1234, 0, 32'h0000_80FF, 4'b1100, 32'h0000_0200, 32'h0);
    run_op("sh",     1'b1, 3'd1, 32'h0000_0302, 32'h1234_ABCD, 3, 1'b0, 32'hFFFF_FFFF, 0, 32'h0,      4'b1100, 32'h0000_0300, 32'hABCD_ABCD);
    run_op("lw_mis", 1'b0, 3'd0, 32'h0000_0101, 32'h0,       0, 1'b0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0);
    run_op("sz6",    1'b0, 3'd6, 32'h0000_0100, 32'h0,       0, 1'b0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0);
    run_op("lhu_mis",1'b0, 3'd3, 32'h0000_0203, 32'h0,       0, 1'b0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0);
    run_op("lw_same",1'b0, 3'd0, 32'h0000_0400, 32'h0,       0, 1'b1, 32'h0000_0055, 0, 32'h0000_0055, 4'b1111, 32'h0000_0400, 32'h0);
    run_op("lh_hi",  1'b0, 3'd1, 32'h0000_0002, 32'h0,       0, 1'b0, 32'h8001_7FFF, 0, 32'hFFFF_8001, 4'b1100, 32'h0000_0000, 32'h0);
    run_op("lh_lo",  1'b0, 3'd1, 32'h0000_0000, 32'h0,       2, 1'b1, 32'h1234_8000, 0, 32'hFFFF_8000, 4'b0011, 32'h0000_0000, 32'h0);
    run_op("lb_pos", 1'b0, 3'd2, 32'h0000_0001, 32'h0,       0, 1'b0, 32'h0000_7F00, 0, 32'h0000_007F, 4'b0010, 32'h0000_0000, 32'h0);
    run_op("sb",     1'b1, 3'd2, 32'h0000_0011, 32'h7654_32A5, 1, 1'b0, 32'h1111_1111, 0, 32'h0,      4'b0010, 32'h0000_0010, 32'hA5A5_A5A5);
    run_op("sw",     1'b1, 3'd0, 32'h0000_0020, 32'h1234_5678, 0, 1'b1, 32'h2222_2222, 0, 32'h0,      4'b1111, 32'h0000_0020, 32'h1234_5678);

    // Abort a load while it waits for its response.
    @(posedge clk_i); #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd0; lsu_addr_i = 32'h0000_0040;
    @(posedge clk_i); #1;
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    lsu_req_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    check("abort_ctrl", {29'd0, lsu_stall_o, lsu_valid_o, lsu_misalign_o, data_req_o, data_we_o}, 34'd0);
    check("abort_bus", {data_be_o, data_addr_o[29:0]}, 34'd0);
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("abort_stale_rvalid", {33'd0, lsu_valid_o}, 34'd0);

    run_op("lw_after", 1'b0, 3'd0, 32'h0000_0044, 32'h0, 0, 1'b0, 32'hC001_D00D, 0, 32'hC001_D00D, 4'b1111, 32'h0000_0044, 32'h0);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("queue_empty", 34'(exp_q.size()), 34'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
